// File: rtl/ddr_sref_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ddr_sref_sequencer_if : AXI-Lite bundle for the SREF sequencer  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface ddr_sref_sequencer_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface
`default_nettype wire

// File: rtl/ddr_sref_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ddr_sref_sequencer : drives DDR4 C0/C2/C3 into/out of self-ref  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module ddr_sref_sequencer #(
   parameter logic [31:0] TIMEOUT_DEFAULT = 32'd25_000_000,
   parameter int          ADDR_W          = 12
) (
   input  wire logic             clk_out_250M,
   input  wire logic             axi_reset_n,
   ddr_sref_sequencer_if.slave   s_axil,
   output logic [7:0]            C0_DDR_SREF_CTRL_IN,
   output logic [7:0]            C2_DDR_SREF_CTRL_IN,
   output logic [7:0]            C3_DDR_SREF_CTRL_IN,
   input  wire logic [7:0]       C0_DDR_SREF_CTRL_OUT,
   input  wire logic [7:0]       C2_DDR_SREF_CTRL_OUT,
   input  wire logic [7:0]       C3_DDR_SREF_CTRL_OUT,
   output logic                  irq
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_QUIESCE = 3'd1,
      S_ENTER   = 3'd2,
      S_INSREF  = 3'd3,
      S_EXIT    = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      cnt_q, cnt_d, timeout_q, timeout_d;
   logic [2:0]       mask_q, mask_d, act_q, act_d;
   logic             done_q, done_d, error_q, error_d, irq_q, irq_d;
   logic [2:0][7:0]  ctl_q, ctl_d, sts_q, sts_d;
   logic             awready_q, awready_d, bvalid_q, bvalid_d;
   logic             arready_q, arready_d, rvalid_q, rvalid_d;
   logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             wr_fire, rd_fire, wr_ok, rd_ok, busy;
   logic             wr_ctrl, wr_stat, wr_tmo, go_enter, go_exit;
   logic [2:0]       idle_v, ack_v, cal_v, sref_v;
   logic             all_idle, all_ack, all_rel, expired;
   logic             unused_ok;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ((a >> 4) == '0) && (a[1:0] == 2'b00);
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         ack_v[i]  = sts_q[i][0];
         cal_v[i]  = sts_q[i][1];
         idle_v[i] = sts_q[i][2];
      end
   end

   // Unmasked channels are forced true so they never hold up a step.
   assign all_idle = &(idle_v | ~act_q);
   assign all_ack  = &(ack_v | ~act_q);
   assign all_rel  = &((~ack_v & cal_v) | ~act_q);
   assign expired  = (cnt_q == 32'd0);
   assign sref_v   = ack_v & act_q;
   assign busy     = (state_q == S_QUIESCE) || (state_q == S_ENTER) ||
                     (state_q == S_EXIT) || (state_q == S_DONE);

   assign wr_fire  = awready_q & s_axil.awvalid & s_axil.wvalid;
   assign rd_fire  = arready_q & s_axil.arvalid;
   assign wr_ok    = addr_ok(s_axil.awaddr);
   assign rd_ok    = addr_ok(s_axil.araddr);
   assign wr_ctrl  = wr_fire & wr_ok & (s_axil.awaddr[3:2] == 2'd0);
   assign wr_stat  = wr_fire & wr_ok & (s_axil.awaddr[3:2] == 2'd1);
   assign wr_tmo   = wr_fire & wr_ok & (s_axil.awaddr[3:2] == 2'd2);
   assign go_enter = wr_ctrl & s_axil.wstrb[0] & s_axil.wdata[0] & ~s_axil.wdata[1];
   assign go_exit  = wr_ctrl & s_axil.wstrb[0] & s_axil.wdata[1] & ~s_axil.wdata[0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      mask_d    = mask_q;
      act_d     = act_q;
      done_d    = done_q;
      error_d   = error_q;
      sts_d     = {C3_DDR_SREF_CTRL_OUT, C2_DDR_SREF_CTRL_OUT, C0_DDR_SREF_CTRL_OUT};

      if (wr_stat) begin
         done_d  = 1'b0;
         error_d = 1'b0;
      end
      if (wr_tmo) begin
         for (int b = 0; b < 4; b++)
            if (s_axil.wstrb[b]) timeout_d[8*b +: 8] = s_axil.wdata[8*b +: 8];
      end
      if (wr_ctrl && s_axil.wstrb[0] && !busy) mask_d = s_axil.wdata[6:4];

      case (state_q)
         S_IDLE: begin
            if (go_enter && (s_axil.wdata[6:4] != 3'b000)) begin
               act_d   = s_axil.wdata[6:4];
               cnt_d   = timeout_q;
               state_d = S_QUIESCE;
            end
         end
         S_QUIESCE: begin
            if (all_idle) begin
               cnt_d   = timeout_q;
               state_d = S_ENTER;
            end else if (expired) state_d = S_ERROR;
            else cnt_d = cnt_q - 32'd1;
         end
         S_ENTER: begin
            if (all_ack) state_d = S_INSREF;
            else if (expired) state_d = S_ERROR;
            else cnt_d = cnt_q - 32'd1;
         end
         S_INSREF: begin
            if (go_exit) begin
               cnt_d   = timeout_q;
               state_d = S_EXIT;
            end
         end
         S_EXIT: begin
            if (all_rel) state_d = S_DONE;
            else if (expired) state_d = S_ERROR;
            else cnt_d = cnt_q - 32'd1;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: if (!error_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Entry into DONE/ERROR outranks a same-cycle clear of the sticky bits.
      if (state_d == S_DONE && state_q != S_DONE)   done_d  = 1'b1;
      if (state_d == S_ERROR && state_q != S_ERROR) error_d = 1'b1;
      irq_d = (state_d != state_q) &&
              ((state_d == S_INSREF) || (state_d == S_DONE) || (state_d == S_ERROR));

      for (int i = 0; i < 3; i++) begin
         ctl_d[i] = 8'h00;
         if (act_q[i]) begin
            case (state_q)
               S_QUIESCE, S_EXIT: ctl_d[i] = 8'h02;
               S_ENTER, S_INSREF: ctl_d[i] = 8'h03;
               default:           ctl_d[i] = 8'h00;
            endcase
         end
      end
   end

   always_comb begin
      awready_d = s_axil.awvalid & s_axil.wvalid & ~bvalid_q & ~awready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_ok ? 2'b00 : 2'b10;
      end else if (bvalid_q && s_axil.bready) bvalid_d = 1'b0;

      arready_d = s_axil.arvalid & ~rvalid_q & ~arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_ok ? 2'b00 : 2'b10;
         rdata_d  = 32'd0;
         if (rd_ok) begin
            case (s_axil.araddr[3:2])
               2'd0:    rdata_d = {25'd0, mask_q, 4'd0};
               2'd1:    rdata_d = {21'd0, sref_v, 1'b0, error_q, done_q, busy, 1'b0, state_q};
               2'd2:    rdata_d = timeout_q;
               default: rdata_d = {8'h00, sts_q[2], sts_q[1], sts_q[0]};
            endcase
         end
      end else if (rvalid_q && s_axil.rready) rvalid_d = 1'b0;
   end

   always_ff @(posedge clk_out_250M) begin
      if (!axi_reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 32'd0;
         timeout_q <= TIMEOUT_DEFAULT;
         mask_q    <= 3'b111;
         act_q     <= 3'b000;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         irq_q     <= 1'b0;
         ctl_q     <= '0;
         sts_q     <= '0;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         mask_q    <= mask_d;
         act_q     <= act_d;
         done_q    <= done_d;
         error_q   <= error_d;
         irq_q     <= irq_d;
         ctl_q     <= ctl_d;
         sts_q     <= sts_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s_axil.awready = awready_q;
   assign s_axil.wready  = awready_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.arready = arready_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rdata   = rdata_q;

   assign C0_DDR_SREF_CTRL_IN = ctl_q[0];
   assign C2_DDR_SREF_CTRL_IN = ctl_q[1];
   assign C3_DDR_SREF_CTRL_IN = ctl_q[2];
   assign irq                 = irq_q;

   assign unused_ok = ^{s_axil.awprot, s_axil.arprot,
                        sts_q[0][7:3], sts_q[1][7:3], sts_q[2][7:3]};
endmodule
`default_nettype wire

// File: tb/tb_ddr_sref_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_ddr_sref_sequencer : randomized scoreboard bench             |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_ddr_sref_sequencer;
   localparam logic [31:0] TMO_DEF = 32'd25_000_000;

   logic clk = 1'b0;
   always #2 clk = ~clk;
   logic rst_n;
   logic irq;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ddr_sref_sequencer_if #(.ADDR_W(12)) axil ();
   wire  [2:0][7:0] c_in;
   logic [2:0][7:0] c_out = {8'h06, 8'h06, 8'h06};

   ddr_sref_sequencer #(.TIMEOUT_DEFAULT(TMO_DEF), .ADDR_W(12)) dut (
      .clk_out_250M         (clk),
      .axi_reset_n          (rst_n),
      .s_axil               (axil.slave),
      .C0_DDR_SREF_CTRL_IN  (c_in[0]),
      .C2_DDR_SREF_CTRL_IN  (c_in[1]),
      .C3_DDR_SREF_CTRL_IN  (c_in[2]),
      .C0_DDR_SREF_CTRL_OUT (c_out[0]),
      .C2_DDR_SREF_CTRL_OUT (c_out[1]),
      .C3_DDR_SREF_CTRL_OUT (c_out[2]),
      .irq                  (irq)
   );

   // Shell model: responsive channels echo sref_req on ack after lat cycles,
   // calib_done is the inverse of ack; others show a stuck ack with no idle.
   int         lat = 6;
   int         age [3] = '{0, 0, 0};
   logic [2:0] resp_mask = 3'b111;
   logic       idle_en = 1'b1;
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!resp_mask[i]) begin
            c_out[i] <= 8'h01;
            age[i]   <= 0;
         end else if (c_in[i][0] != c_out[i][0] && age[i] < lat) begin
            age[i]   <= age[i] + 1;
            c_out[i] <= {5'b0, idle_en, ~c_out[i][0], c_out[i][0]};
         end else begin
            age[i]   <= 0;
            c_out[i] <= {5'b0, idle_en, ~c_in[i][0], c_in[i][0]};
         end
      end
   end

   int n_pass = 0, n_chk = 0;
   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endfunction
   function automatic void fail_now(string nm);
      n_chk++;
      $display("FAIL %s: got timeout expected DUT response", nm);
   endfunction

   // Reference model
   int         m_state = 0;
   logic [2:0] m_mask = 3'b111, m_act = 3'b000;
   logic       m_done = 1'b0, m_err = 1'b0;
   logic [31:0] m_tmo = TMO_DEF;
   int         m_irq = 0;

   function automatic logic [31:0] status_exp();
      logic [2:0] sref = (m_state == 3) ? m_act : 3'b000;
      logic       busy = (m_state == 1) || (m_state == 2) || (m_state == 4) || (m_state == 5);
      return {21'd0, sref, 1'b0, m_err, m_done, busy, 1'b0, 3'(m_state)};
   endfunction
   function automatic logic [31:0] raw_exp();
      logic [7:0] b [3];
      for (int i = 0; i < 3; i++) b[i] = resp_mask[i] ? {5'b0, idle_en, 2'b01} : 8'h01;
      return {8'h00, b[2], b[1], b[0]};
   endfunction
   function automatic void check_cin(string nm);
      for (int i = 0; i < 3; i++)
         check(nm, 32'(c_in[i]), (m_state == 3 && m_act[i]) ? 32'h3 : 32'h0);
   endfunction
   function automatic logic addr_ok(logic [11:0] a);
      return (a < 12'h010) && (a[1:0] == 2'b00);
   endfunction

   // Scoreboard queues and monitor
   logic [31:0] rq_d [$];
   logic [1:0]  rq_r [$];
   string       rq_n [$];
   logic [1:0]  bq_r [$];
   int irq_cnt = 0;
   always @(negedge clk) begin
      if (irq) irq_cnt++;
      if (axil.rvalid && axil.rready) begin
         if (rq_d.size() == 0) fail_now("rd_unexpected");
         else begin
            string nm = rq_n.pop_front();
            check(nm, axil.rdata, rq_d.pop_front());
            check({nm, "_rresp"}, 32'(axil.rresp), 32'(rq_r.pop_front()));
         end
      end
      if (axil.bvalid && axil.bready) begin
         if (bq_r.size() == 0) fail_now("wr_unexpected");
         else check("bresp", 32'(axil.bresp), 32'(bq_r.pop_front()));
      end
   end

   int last_wr_cyc = 0;
   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input bit wait_b);
      bit got = 1'b0;
      bq_r.push_back(addr_ok(a) ? 2'b00 : 2'b10);
      @(negedge clk);
      axil.awaddr = a; axil.wdata = d; axil.wstrb = 4'hf;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (axil.awready && axil.wready) got = 1'b1;
      end
      if (!got) fail_now("aw_handshake");
      @(posedge clk); #1;
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      last_wr_cyc = cyc;
      if (wait_b) begin
         got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (!axil.bvalid) got = 1'b1;
         end
         if (!got) fail_now("b_drain");
      end
   endtask

   task automatic axi_read(input logic [11:0] a, input logic [31:0] d, input string nm);
      bit got = 1'b0;
      rq_d.push_back(d); rq_r.push_back(addr_ok(a) ? 2'b00 : 2'b10); rq_n.push_back(nm);
      @(negedge clk);
      axil.araddr = a; axil.arvalid = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (axil.arready) got = 1'b1;
      end
      if (!got) fail_now({nm, "_ar"});
      @(posedge clk); #1;
      axil.arvalid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (rq_d.size() == 0) got = 1'b1;
      end
      if (!got) fail_now({nm, "_r"});
   endtask

   int t_irq = 0;
   task automatic wait_irq(input string nm, input int budget);
      bit got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk);
         if (irq) begin got = 1'b1; t_irq = cyc; end
      end
      if (!got) fail_now(nm);
      else m_irq++;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1);
   end

   initial begin
      bit seen_low, seen_acc, got;
      axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
      axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b1;
      axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b1;
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;

      check_cin("rst_ctrl_in");
      axi_read(12'h000, 32'h70, "rst_ctrl");
      axi_read(12'h004, 32'h0, "rst_status");
      axi_read(12'h008, TMO_DEF, "rst_timeout");

      m_tmo = 32'd1000;
      axi_write(12'h008, m_tmo, 1'b1);
      axi_write(12'h000, 32'h73, 1'b1);
      axi_read(12'h004, status_exp(), "both_go_ignored");
      axi_write(12'h000, 32'h72, 1'b1);
      axi_read(12'h004, status_exp(), "exit_in_idle_ignored");

      for (int it = 0; it < 5; it++) begin
         m_mask    = (it == 0) ? 3'b111 : (it == 1) ? 3'b010 : 3'($urandom_range(1, 7));
         lat       = $urandom_range(6, 15);
         resp_mask = m_mask;
         idle_en   = 1'b1;
         axi_write(12'h004, 32'h0, 1'b1);
         m_done = 1'b0;
         axi_write(12'h000, {25'd0, m_mask, 4'b0001}, 1'b1);
         m_state = 1; m_act = m_mask;
         axi_write(12'h000, 32'h0, 1'b1);
         wait_irq("insref_irq", 300);
         m_state = 3;
         repeat (2) @(negedge clk);
         check_cin("insref_ctrl_in");
         check("irq_count", irq_cnt, m_irq);
         axi_read(12'h004, status_exp(), "insref_status");
         axi_read(12'h000, {25'd0, m_mask, 4'd0}, "mask_held_busy");
         axi_read(12'h00C, raw_exp(), "raw");
         axi_write(12'h000, {25'd0, m_mask, 4'b0010}, 1'b1);
         wait_irq("done_irq", 300);
         m_state = 0; m_done = 1'b1;
         repeat (2) @(negedge clk);
         check_cin("done_ctrl_in");
         check("irq_count", irq_cnt, m_irq);
         axi_read(12'h004, status_exp(), "done_status");
      end

      // Timeout in QUIESCE
      idle_en = 1'b0; resp_mask = 3'b111; m_mask = 3'b111;
      m_tmo = 32'd100;
      axi_write(12'h008, m_tmo, 1'b1);
      axi_read(12'h008, m_tmo, "timeout_rw");
      axi_write(12'h004, 32'h0, 1'b1);
      m_done = 1'b0;
      axi_write(12'h000, 32'h71, 1'b0);
      m_state = 1; m_act = 3'b111;
      wait_irq("error_irq", 300);
      check("tmo_latency", 32'(t_irq - last_wr_cyc >= 100 && t_irq - last_wr_cyc <= 102), 32'd1);
      m_state = 6; m_err = 1'b1;
      repeat (2) @(negedge clk);
      check_cin("error_ctrl_in");
      check("irq_count", irq_cnt, m_irq);
      axi_read(12'h004, status_exp(), "error_status");
      axi_write(12'h004, 32'h0, 1'b1);
      m_state = 0; m_err = 1'b0;
      axi_read(12'h004, status_exp(), "error_cleared");
      idle_en = 1'b1;

      // Bad offsets
      axi_read(12'h010, 32'h0, "bad_rd");
      axi_write(12'h014, 32'h1234, 1'b1);
      axi_read(12'h008, m_tmo, "bad_wr_dropped");

      // Stalled write response blocks a second write
      axil.bready = 1'b0;
      axi_write(12'h008, 32'd500, 1'b0);
      bq_r.push_back(2'b00);
      @(negedge clk);
      axil.awaddr = 12'h008; axil.wdata = 32'd777; axil.wstrb = 4'hf;
      axil.awvalid = 1'b1; axil.wvalid = 1'b1;
      seen_low = 1'b0; seen_acc = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!axil.bvalid) seen_low = 1'b1;
         if (axil.awready) seen_acc = 1'b1;
      end
      check("bvalid_held", 32'(seen_low), 32'd0);
      check("no_second_write", 32'(seen_acc), 32'd0);
      axil.bready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (axil.awready) got = 1'b1;
      end
      if (!got) fail_now("second_write");
      @(posedge clk); #1;
      axil.awvalid = 1'b0; axil.wvalid = 1'b0;
      repeat (3) @(negedge clk);
      m_tmo = 32'd777;
      axi_read(12'h008, m_tmo, "second_write_data");

      // Reset during ENTER
      lat = 40;
      axi_write(12'h000, 32'h71, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (c_in[0] == 8'h03) got = 1'b1;
      end
      if (!got) fail_now("reach_enter");
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_state = 0; m_act = 3'b000; m_mask = 3'b111; m_tmo = TMO_DEF;
      check_cin("reset_mid_ctrl_in");
      axi_read(12'h004, status_exp(), "reset_mid_status");
      axi_read(12'h000, 32'h70, "reset_mid_ctrl");
      axi_read(12'h008, m_tmo, "reset_mid_timeout");

      repeat (5) @(negedge clk);
      check("sb_drained", rq_d.size() + bq_r.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
